// File: rtl/block_scanner.sv
// block_scanner: walks a 2-row, WIN_W-wide window across a latched row pair
// at a fixed stride and emits each window over a valid/ready handshake.
module block_scanner #(
    parameter int ROW_WIDTH = 512,
    parameter int WIN_W = 3,
    parameter int STRIDE = 1,
    localparam int NPOS = (ROW_WIDTH - WIN_W) / STRIDE + 1,
    localparam int PW = (NPOS > 1) ? $clog2(NPOS) : 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic [ROW_WIDTH-1:0] i_1st_row,
    input  logic [ROW_WIDTH-1:0] i_2nd_row,
    input  logic                 i_bottom_or_top_search,
    input  logic                 i_skip_empty,
    input  logic                 i_ready,
    output logic [2*WIN_W-1:0]   o_block,
    output logic                 o_valid,
    output logic [PW-1:0]        o_pos,
    output logic                 o_last,
    output logic                 o_busy,
    output logic                 o_done
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SCAN = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam int IW = (ROW_WIDTH > 1) ? $clog2(ROW_WIDTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(NPOS - 1);

    logic [1:0]           state;
    logic [PW-1:0]        pos;
    logic [ROW_WIDTH-1:0] row1, row2;
    logic                 dir, skip;
    logic [WIN_W-1:0]     win1, win2;
    logic                 empty, adv;

    // Window bit i is taken walking away from the scan origin, so the
    // bit nearest the origin always lands in the MSB of each half.
    always_comb begin
        win1 = '0;
        win2 = '0;
        for (int i = 0; i < WIN_W; i++) begin
            int b;
            logic [IW-1:0] ix;
            b = int'(pos) * STRIDE;
            ix = IW'(dir ? b + i : ROW_WIDTH - 1 - b - i);
            win1[WIN_W-1-i] = row1[ix];
            win2[WIN_W-1-i] = row2[ix];
        end
    end

    assign o_block = {win1, win2};
    assign empty   = ~|o_block;
    assign o_valid = (state == SCAN) && !(skip && empty);
    assign adv     = (state == SCAN) && (i_ready || (skip && empty));
    assign o_pos   = pos;
    assign o_last  = (state == SCAN) && (pos == LAST);
    assign o_busy  = state != IDLE;
    assign o_done  = state == DONE;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
            pos   <= '0;
            row1  <= '0;
            row2  <= '0;
            dir   <= 1'b0;
            skip  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (i_start) begin
                    state <= SCAN;
                    pos   <= '0;
                    row1  <= i_1st_row;
                    row2  <= i_2nd_row;
                    dir   <= i_bottom_or_top_search;
                    skip  <= i_skip_empty;
                end
                SCAN: if (adv) begin
                    if (pos == LAST) state <= DONE;
                    else pos <= pos + PW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_block_scanner.sv
// tb_block_scanner: directed vectors for three parameterisations of block_scanner.
module tb_block_scanner;
    logic clk = 1'b0, rst_n = 1'b0;
    logic dir = 1'b0, skip = 1'b0, ready = 1'b1;
    logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
    logic [7:0] r1a = '0, r2a = '0, r1b = '0, r2b = '0;
    logic [511:0] r1c = '0, r2c = '0;
    logic [5:0] blk_a, blk_c;
    logic [3:0] blk_b;
    logic [2:0] pos_a;
    logic [1:0] pos_b;
    logic [8:0] pos_c;
    logic val_a, last_a, busy_a, done_a;
    logic val_b, last_b, busy_b, done_b;
    logic val_c, last_c, busy_c, done_c;
    int pass_cnt = 0, tot = 0;

    always #5 clk = ~clk;

    block_scanner #(.ROW_WIDTH(8), .WIN_W(3), .STRIDE(1)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start_a), .i_1st_row(r1a), .i_2nd_row(r2a),
        .i_bottom_or_top_search(dir), .i_skip_empty(skip), .i_ready(ready),
        .o_block(blk_a), .o_valid(val_a), .o_pos(pos_a), .o_last(last_a), .o_busy(busy_a), .o_done(done_a));

    block_scanner #(.ROW_WIDTH(8), .WIN_W(2), .STRIDE(2)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start_b), .i_1st_row(r1b), .i_2nd_row(r2b),
        .i_bottom_or_top_search(dir), .i_skip_empty(skip), .i_ready(ready),
        .o_block(blk_b), .o_valid(val_b), .o_pos(pos_b), .o_last(last_b), .o_busy(busy_b), .o_done(done_b));

    block_scanner dut_c (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start_c), .i_1st_row(r1c), .i_2nd_row(r2c),
        .i_bottom_or_top_search(dir), .i_skip_empty(skip), .i_ready(ready),
        .o_block(blk_c), .o_valid(val_c), .o_pos(pos_c), .o_last(last_c), .o_busy(busy_c), .o_done(done_c));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tot++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    typedef struct {
        logic [7:0]  r1, r2;
        logic        d, s;
        logic [35:0] blks;
        logic [5:0]  vm;
    } vec_t;

    vec_t tv[5];
    logic [3:0] eb[4];
    int idx, beats, lastpos, lc, dc, errs;
    logic seen;
    logic [5:0] e6;

    initial begin
        tv[0] = '{8'b00000111, 8'b00000001, 1'b1, 1'b0,
                  {6'b111100, 6'b110000, 6'b100000, 6'b000000, 6'b000000, 6'b000000}, 6'b111111};
        tv[1] = '{8'b00000111, 8'b00000001, 1'b1, 1'b1,
                  {6'b111100, 6'b110000, 6'b100000, 6'b000000, 6'b000000, 6'b000000}, 6'b000111};
        tv[2] = '{8'b11100000, 8'b10100000, 1'b0, 1'b0,
                  {6'b111101, 6'b110010, 6'b100100, 6'b000000, 6'b000000, 6'b000000}, 6'b111111};
        tv[3] = '{8'b10000001, 8'b00000000, 1'b1, 1'b1,
                  {6'b100000, 6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b001000}, 6'b100001};
        tv[4] = '{8'b01010101, 8'b11001100, 1'b0, 1'b0,
                  {6'b010110, 6'b101100, 6'b010001, 6'b101011, 6'b010110, 6'b101100}, 6'b111111};
        eb = '{4'b1001, 4'b1110, 4'b0011, 4'b0100};

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_valid", val_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_last", last_a, 0);
        chk("rst_pos", pos_a, 0);
        chk("rst_block", blk_a, 0);
        rst_n = 1'b1;

        // table-driven scans on the 8/3/1 instance
        for (int v = 0; v < 5; v++) begin
            @(negedge clk);
            r1a = tv[v].r1; r2a = tv[v].r2; dir = tv[v].d; skip = tv[v].s; ready = 1'b1;
            start_a = 1'b1;
            @(negedge clk);
            start_a = 1'b0; r1a = ~r1a; r2a = 8'hA5;
            for (int k = 0; k < 6; k++) begin
                if (k > 0) @(negedge clk);
                chk($sformatf("v%0d_k%0d_valid", v, k), val_a, tv[v].vm[k]);
                chk($sformatf("v%0d_k%0d_busy", v, k), busy_a, 1);
                if (tv[v].vm[k]) begin
                    chk($sformatf("v%0d_k%0d_block", v, k), blk_a, tv[v].blks[35-6*k -: 6]);
                    chk($sformatf("v%0d_k%0d_pos", v, k), pos_a, k);
                    chk($sformatf("v%0d_k%0d_last", v, k), last_a, k == 5);
                end
            end
            @(negedge clk);
            chk($sformatf("v%0d_done", v), done_a, 1);
            chk($sformatf("v%0d_done_busy", v), busy_a, 1);
            @(negedge clk);
            chk($sformatf("v%0d_idle_done", v), done_a, 0);
            chk($sformatf("v%0d_idle_busy", v), busy_a, 0);
        end

        // 8/2/2 instance with ready toggling and rows changing mid-scan
        @(negedge clk);
        r1b = 8'b10110001; r2b = 8'b01101100; dir = 1'b0; skip = 1'b0; ready = 1'b1; start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        idx = 0; seen = 1'b0;
        for (int c = 0; c < 30 && !seen; c++) begin
            if (c > 0) @(negedge clk);
            r1b = 8'($urandom); r2b = 8'($urandom);
            if (done_b) seen = 1'b1;
            else if (val_b) begin
                chk($sformatf("b_c%0d_block", c), blk_b, eb[idx]);
                chk($sformatf("b_c%0d_pos", c), pos_b, idx);
                chk($sformatf("b_c%0d_last", c), last_b, idx == 3);
                ready = (c % 2 == 0);
                if (ready) idx++;
            end
        end
        chk("b_beats", idx, 4);
        chk("b_done_seen", seen, 1);

        // async reset mid-scan with ready low, then fresh restart
        @(negedge clk);
        r1b = 8'b11000011; r2b = 8'b00111100; ready = 1'b1; start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        for (int c = 0; c < 10 && pos_b != 2; c++) @(negedge clk);
        chk("b_pos2_reached", pos_b, 2);
        ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", val_b, 0);
        chk("arst_busy", busy_b, 0);
        chk("arst_done", done_b, 0);
        chk("arst_last", last_b, 0);
        chk("arst_pos", pos_b, 0);
        chk("arst_block", blk_b, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst_no_done", done_b, 0);
        r1b = 8'b01000010; r2b = 8'b10011001; ready = 1'b1; start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        chk("restart_valid", val_b, 1);
        chk("restart_pos", pos_b, 0);
        chk("restart_block", blk_b, 4'b0110);
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            seen = done_b;
        end
        chk("restart_done", seen, 1);
        @(negedge clk);

        // back-to-back scans with start held high
        r1a = 8'hF0; r2a = 8'h0F; dir = 1'b0; skip = 1'b0; ready = 1'b1; start_a = 1'b1;
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            chk($sformatf("bb_c%0d_busy", c), busy_a, c % 8 != 7);
            chk($sformatf("bb_c%0d_done", c), done_a, c % 8 == 6);
            if (c % 8 < 6) chk($sformatf("bb_c%0d_pos", c), pos_a, c % 8);
        end
        start_a = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            seen = !busy_a;
        end
        chk("bb_idle", seen, 1);

        // default 512/3/1 full sweep
        r1c = {3'b111, 509'b0}; r2c = {3'b101, 509'b0}; dir = 1'b0; skip = 1'b0; ready = 1'b1;
        start_c = 1'b1;
        @(negedge clk);
        start_c = 1'b0;
        chk("c_first_valid", val_c, 1);
        chk("c_first_block", blk_c, 6'b111101);
        chk("c_first_pos", pos_c, 0);
        beats = 0; lastpos = -1; lc = -1; dc = -1; errs = 0; seen = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (c > 0) @(negedge clk);
            if (done_c) begin
                seen = 1'b1;
                dc = c;
                break;
            end
            if (val_c) begin
                e6 = (beats == 0) ? 6'b111101 : (beats == 1) ? 6'b110010 : (beats == 2) ? 6'b100100 : 6'b0;
                if (blk_c !== e6 || pos_c !== 9'(beats)) errs++;
                if (last_c) begin
                    lastpos = int'(pos_c);
                    lc = c;
                end
                beats++;
            end
        end
        chk("c_done_seen", seen, 1);
        chk("c_beats", beats, 510);
        chk("c_block_errs", errs, 0);
        chk("c_last_pos", lastpos, 509);
        chk("c_done_after_last", dc, lc + 1);

        $display("%0d/%0d checks passed", pass_cnt, tot);
        $finish;
    end
endmodule

// File: doc/block_scanner.md
# block_scanner

Sequential, parametrised window scanner for the connected-domain filter. Latches a pair of adjacent image rows and walks a WIN_W-wide, 2-row window across them at a fixed stride, in either scan direction. Each window is emitted over a valid/ready handshake, and all-zero windows can optionally be skipped. It sits between the row buffer and the connectivity/labelling logic, and generalises single-position block extraction to a full row sweep.

## Interface
- ROW_WIDTH, 512, bits per row
- WIN_W, 3, window width in bits per row; 1 ≤ WIN_W ≤ ROW_WIDTH
- STRIDE, 1, position step in bits; (ROW_WIDTH−WIN_W) must be divisible by STRIDE
- Derived: NPOS = (ROW_WIDTH−WIN_W)/STRIDE + 1; PW = max(1, clog2(NPOS))
- i_clk  input  1  clock, rising edge
- i_rst_n  input  1  asynchronous active-low reset
- i_start  input  1  start pulse; accepted only in IDLE
- i_1st_row  input  ROW_WIDTH  upper row, sampled on accepted start
- i_2nd_row  input  ROW_WIDTH  lower row, sampled on accepted start
- i_bottom_or_top_search  input  1  0: scan from MSB end downward; 1: scan from LSB end upward; sampled on start
- i_skip_empty  input  1  1: suppress all-zero windows; sampled on start
- i_ready  input  1  downstream ready
- o_block  output  2*WIN_W  current window
- o_valid  output  1  o_block/o_pos/o_last valid
- o_pos  output  PW  position index k of current window
- o_last  output  1  current window is at k = NPOS−1
- o_busy  output  1  state ≠ IDLE
- o_done  output  1  one-cycle pulse at scan completion

## Operation
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - If i_start = 1, latch both rows, the direction bit and the skip bit into registers.
  - Clear pos to 0 and go to SCAN.
- Window at position k, with b = k*STRIDE:
  - Direction 0: o_block = {row1[ROW_WIDTH−1−b −: WIN_W], row2[ROW_WIDTH−1−b −: WIN_W]}.
  - Direction 1: o_block = {row1[b], row1[b+1], …, row1[b+WIN_W−1], row2[b], …, row2[b+WIN_W−1]}. row1[b] is the MSB of o_block.
- o_block is a combinational mux of the latched rows and the pos register. It does not depend on the live row inputs.
- empty = (o_block == 0).
- SCAN:
  - o_valid = !(skip && empty).
  - Advance pos when (o_valid && i_ready) or (skip && empty). Exactly one position per cycle at most.
  - If the advance happens at pos = NPOS−1, go to DONE instead of incrementing.
- o_valid, o_block, o_pos and o_last hold stable while o_valid = 1 and i_ready = 0.
- o_last = (state == SCAN) && (pos == NPOS−1). It is only meaningful while o_valid = 1. If the final window is skipped, no o_last beat is emitted.
- DONE: o_done = 1 for one cycle, then return to IDLE.
- i_start is ignored in SCAN and DONE, and the latched data is unchanged.
- Row inputs may change freely once the start has been accepted.

## Timing
- Reset (async assert, sync deassert assumed upstream):
  - state = IDLE, pos = 0, latched rows/flags = 0.
  - Outputs: o_valid = 0, o_busy = 0, o_done = 0, o_last = 0, o_pos = 0, o_block = 0.
- Reset during SCAN aborts immediately:
  - no o_done, no further beats;
  - the next i_start after release starts a fresh scan.
- Start latency: i_start sampled high at edge n → o_busy = 1 and first window presented in cycle n+1.
- Throughput: one window per cycle with i_ready held high.
  - No skip: full scan = NPOS SCAN cycles + 1 DONE cycle.
  - o_busy stays high through the DONE cycle and drops the cycle after.
- Skipped positions cost one cycle each, with o_valid = 0.
- Earliest restart: i_start accepted in the cycle after DONE (in IDLE). Back-to-back scan period = NPOS+2 cycles.
- Degenerate NPOS = 1: single window with o_last = 1, then DONE.
- Handshake rule: downstream may hold i_ready low indefinitely; no data is lost or reordered.

## Test plan
- Default parameters, row1 = 512'b111 << 509, row2 = 512'b101 << 509, direction 0, no skip, i_ready = 1 → first beat o_block = 6'b111101, o_pos = 0, one cycle after start. 510 beats total, o_last on o_pos = 509, o_done one cycle later.
- ROW_WIDTH = 8, WIN_W = 3, STRIDE = 1, row1 = 8'b0000_0111, row2 = 8'b0000_0001, direction 1 → beats k = 0..5: 111100, 110000, 100000, 000000, 000000, 000000.
- Same as above with i_skip_empty = 1 → only k = 0, 1, 2 emitted. No o_last beat. o_done pulses 7 cycles after start.
- ROW_WIDTH = 8, WIN_W = 2, STRIDE = 2, direction 0, i_ready toggled 1/0 every cycle → 4 beats (o_pos 0..3), each held stable while i_ready = 0. Change the row inputs mid-scan → outputs are unaffected.
- Assert i_rst_n = 0 at o_pos = 2 with i_ready = 0 → all outputs 0 asynchronously. After release, i_start → scan restarts at o_pos = 0 with newly sampled rows.
- i_start held high continuously → scans run back-to-back with exactly one IDLE cycle between o_done and the next o_busy rise. i_start during SCAN does not disturb pos.
